sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Two-client arbiter and transaction sequencer in front of the SDRAM controller's single-word user interface (`addr`/`rd_req`/`wr_req`/`wr_data`/`rd_data`/`rd_valid`/`wr_ready`). Port 0 carries the UART-RX write path and port 1 the UART-TX read path. The block grants one client at a time using round-robin order. It holds the controller request level-high until completion, returns a one-cycle ack with read data, and aborts with an error if the controller does not respond.

## Interface
- `TIMEOUT_CYC`, default 64: cycles in a WAIT state before abort (2..255).
- `clk_100MHz`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `c0_req`  in  1  client 0 request. Held with `c0_we`/`c0_addr`/`c0_wdata` stable until `c0_ack`.
- `c0_we`  in  1  1 = write, 0 = read.
- `c0_addr`  in  24  word address {bank[1:0], row[12:0], col[8:0]}.
- `c0_wdata`  in  16  write data.
- `c0_ack`  out  1  one-cycle completion pulse.
- `c0_err`  out  1  valid with `c0_ack`; 1 = timed out.
- `c0_rdata`  out  16  read data; valid with `c0_ack` for reads; held until the next client-0 read ack.
- `c1_req`, `c1_we`, `c1_addr`, `c1_wdata`, `c1_ack`, `c1_err`, `c1_rdata`: same as client 0.
- `mem_addr`  out  24  to controller `addr`.
- `mem_wr_data`  out  16  to controller `wr_data`.
- `mem_rd_req`  out  1  to controller `rd_req`.
- `mem_wr_req`  out  1  to controller `wr_req`.
- `mem_rd_data`  in  16  from controller `rd_data`.
- `mem_rd_valid`  in  1  from controller `rd_valid`. May stay high up to 2 cycles.
- `mem_wr_ready`  in  1  from controller `wr_ready`. One-cycle pulse.
- `busy`  out  1  high in any state other than IDLE.
- `owner`  out  1  client index of the current or most recent grant.

## Operation
- States: IDLE, WAIT_WR, WAIT_RD, GAP. All outputs are registered.
- IDLE:
  - Arbitrate among asserted `cN_req`.
  - If both are asserted, grant the client that is not `owner`.
  - On grant:
    - latch `addr`/`wdata` into `mem_addr`/`mem_wr_data`;
    - set `owner`;
    - clear the timeout counter;
    - assert `mem_wr_req` (we=1) → WAIT_WR, or `mem_rd_req` (we=0) → WAIT_RD.
- WAIT_WR:
  - `mem_wr_ready`=1 → drop `mem_wr_req`, pulse `cN_ack` with err=0, → GAP.
- WAIT_RD:
  - `mem_rd_valid`=1 → drop `mem_rd_req`, capture `mem_rd_data` into `cN_rdata`, pulse ack with err=0, → GAP.
- Timeout:
  - In either WAIT state the counter increments each cycle.
  - Counter reaching `TIMEOUT_CYC`-1 with no completion → drop request, pulse ack with err=1, `cN_rdata` unchanged, → GAP.
  - Completion and timeout in the same cycle: completion wins, err=0.
- GAP:
  - One cycle; then → IDLE.
  - Guarantees the controller samples the request low in its IDLE cycle.
  - Masks the trailing second cycle of `mem_rd_valid`.
- `mem_rd_valid`/`mem_wr_ready` seen in IDLE or GAP are ignored.
- A WAIT state ignores the completion type it is not waiting for.
- Client dropping `req` mid-transaction: ignored. The transaction completes and ack still pulses.
- Never more than one of `mem_rd_req`/`mem_wr_req` high; never both acks high.

## Timing
- Reset values:
  - `mem_rd_req`=0, `mem_wr_req`=0, `mem_addr`=0, `mem_wr_data`=0;
  - `c0_ack`=`c1_ack`=0, `c0_err`=`c1_err`=0, `c0_rdata`=`c1_rdata`=0;
  - `busy`=0, `owner`=1, so client 0 wins the first contention; state IDLE.
- Request sampled at edge E → `mem_*_req` high and `busy`=1 from E.
- Completion input sampled at edge F:
  - ack pulses for exactly the cycle after F;
  - `mem_*_req` is low from F;
  - state is GAP for one cycle, then IDLE at F+2.
- Earliest next grant: edge F+2.
- End-to-end write latency with the controller: 5 cycles from request sample to ack.
- Reset asserted mid-transaction: all outputs return to reset values immediately. No ack is issued for the aborted transaction.

## Test plan
- Single write c0 addr=0x123456 data=0xBEEF; controller model pulses `mem_wr_ready` 3 cycles after the request:
  - `mem_wr_req` high for exactly 3 cycles, `mem_addr`=0x123456;
  - `c0_ack` one cycle, `c0_err`=0.
- Single read c1 addr=0x000010; model returns 0x5A5A with `mem_rd_valid` held 2 cycles:
  - exactly one `c1_ack`, `c1_rdata`=0x5A5A;
  - no second transaction issued.
- Both clients request continuously from reset:
  - grants alternate c0, c1, c0, c1;
  - 4 acks in order, never overlapping.
- Model never completes, TIMEOUT_CYC=64:
  - request drops after 64 cycles;
  - `cN_ack`=1 with `cN_err`=1, `cN_rdata` unchanged.
- `rst_n` pulsed low during WAIT_RD:
  - `mem_rd_req`=0, `busy`=0 immediately;
  - no ack;
  - the next request is served normally.
- c0 drops `req` one cycle after grant:
  - transaction completes and ack pulses;
  - with c1 waiting, c1 is granted at F+2.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Two-client round-robin arbiter and single-word transaction sequencer for the SDRAM controller user port.
// Holds the controller request until completion, returns a one-cycle ack, and aborts after TIMEOUT_CYC cycles.
module sdram_port_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk_100MHz,
    input  logic        rst_n,
    input  logic        c0_req,
    input  logic        c0_we,
    input  logic [23:0] c0_addr,
    input  logic [15:0] c0_wdata,
    output logic        c0_ack,
    output logic        c0_err,
    output logic [15:0] c0_rdata,
    input  logic        c1_req,
    input  logic        c1_we,
    input  logic [23:0] c1_addr,
    input  logic [15:0] c1_wdata,
    output logic        c1_ack,
    output logic        c1_err,
    output logic [15:0] c1_rdata,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_wr_data,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    input  logic [15:0] mem_rd_data,
    input  logic        mem_rd_valid,
    input  logic        mem_wr_ready,
    output logic        busy,
    output logic        owner
);
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_WR = 2'd1,
        S_WAIT_RD = 2'd2,
        S_GAP     = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_owner, w_owner_nxt;
    logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DW-1:0] r_mem_wr_data, w_mem_wr_data_nxt;
    logic          r_mem_rd_req, w_mem_rd_req_nxt;
    logic          r_mem_wr_req, w_mem_wr_req_nxt;
    logic [1:0]    r_ack, w_ack_nxt;
    logic [1:0]    r_err, w_err_nxt;
    logic [DW-1:0] r_rdata0, w_rdata0_nxt;
    logic [DW-1:0] r_rdata1, w_rdata1_nxt;
    logic          r_busy, w_busy_nxt;

    logic          w_gnt_vld;
    logic          w_gnt_idx;
    logic          w_gnt_we;
    logic [AW-1:0] w_gnt_addr;
    logic [DW-1:0] w_gnt_wdata;
    logic          w_in_wait;
    logic          w_done;
    logic          w_timeout;

    // On contention the client that was not served most recently wins.
    always_comb begin
        w_gnt_vld   = c0_req | c1_req;
        w_gnt_idx   = (c0_req && c1_req) ? ~r_owner : c1_req;
        w_gnt_we    = w_gnt_idx ? c1_we    : c0_we;
        w_gnt_addr  = w_gnt_idx ? c1_addr  : c0_addr;
        w_gnt_wdata = w_gnt_idx ? c1_wdata : c0_wdata;
    end

    // Only the completion type matching the current WAIT state counts; completion beats timeout.
    assign w_in_wait = (r_state == S_WAIT_WR) || (r_state == S_WAIT_RD);
    assign w_done    = ((r_state == S_WAIT_WR) && mem_wr_ready) ||
                       ((r_state == S_WAIT_RD) && mem_rd_valid);
    assign w_timeout = w_in_wait && (r_cnt == CW'(TIMEOUT_CYC - 1)) && !w_done;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_owner       <= 1'b1;
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
            r_mem_rd_req  <= 1'b0;
            r_mem_wr_req  <= 1'b0;
            r_ack         <= 2'b00;
            r_err         <= 2'b00;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_owner       <= w_owner_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_wr_data <= w_mem_wr_data_nxt;
            r_mem_rd_req  <= w_mem_rd_req_nxt;
            r_mem_wr_req  <= w_mem_wr_req_nxt;
            r_ack         <= w_ack_nxt;
            r_err         <= w_err_nxt;
            r_rdata0      <= w_rdata0_nxt;
            r_rdata1      <= w_rdata1_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:    if (w_gnt_vld) w_state_nxt = w_gnt_we ? S_WAIT_WR : S_WAIT_RD;
            S_WAIT_WR,
            S_WAIT_RD: if (w_done || w_timeout) w_state_nxt = S_GAP;
            S_GAP:     w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        w_cnt_nxt         = r_cnt;
        w_owner_nxt       = r_owner;
        w_mem_addr_nxt    = r_mem_addr;
        w_mem_wr_data_nxt = r_mem_wr_data;
        w_mem_rd_req_nxt  = r_mem_rd_req;
        w_mem_wr_req_nxt  = r_mem_wr_req;
        w_ack_nxt         = 2'b00;
        w_err_nxt         = 2'b00;
        w_rdata0_nxt      = r_rdata0;
        w_rdata1_nxt      = r_rdata1;
        w_busy_nxt        = (w_state_nxt != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                if (w_gnt_vld) begin
                    w_mem_addr_nxt    = w_gnt_addr;
                    w_mem_wr_data_nxt = w_gnt_wdata;
                    w_owner_nxt       = w_gnt_idx;
                    w_cnt_nxt         = '0;
                    w_mem_wr_req_nxt  = w_gnt_we;
                    w_mem_rd_req_nxt  = !w_gnt_we;
                end
            end
            S_WAIT_WR, S_WAIT_RD: begin
                if (w_done || w_timeout) begin
                    w_mem_rd_req_nxt   = 1'b0;
                    w_mem_wr_req_nxt   = 1'b0;
                    w_ack_nxt[r_owner] = 1'b1;
                    w_err_nxt[r_owner] = w_timeout;
                    if (w_done && (r_state == S_WAIT_RD)) begin
                        if (r_owner) w_rdata1_nxt = mem_rd_data;
                        else         w_rdata0_nxt = mem_rd_data;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: ;
        endcase
    end

    assign mem_addr    = r_mem_addr;
    assign mem_wr_data = r_mem_wr_data;
    assign mem_rd_req  = r_mem_rd_req;
    assign mem_wr_req  = r_mem_wr_req;
    assign c0_ack      = r_ack[0];
    assign c1_ack      = r_ack[1];
    assign c0_err      = r_err[0];
    assign c1_err      = r_err[1];
    assign c0_rdata    = r_rdata0;
    assign c1_rdata    = r_rdata1;
    assign busy        = r_busy;
    assign owner       = r_owner;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus randomized two-client traffic against a
// memory-level reference model, with a small SDRAM-controller responder model.
module tb_sdram_port_arbiter;
    logic        clk_100MHz;
    logic        rst_n;
    logic        c0_req, c0_we, c1_req, c1_we;
    logic [23:0] c0_addr, c1_addr;
    logic [15:0] c0_wdata, c1_wdata;
    logic        c0_ack, c0_err, c1_ack, c1_err;
    logic [15:0] c0_rdata, c1_rdata;
    logic [23:0] mem_addr;
    logic [15:0] mem_wr_data, mem_rd_data;
    logic        mem_rd_req, mem_wr_req, mem_rd_valid, mem_wr_ready;
    logic        busy, owner;
    logic [1:0]  acks;

    assign acks = {c1_ack, c0_ack};

    sdram_port_arbiter #(.TIMEOUT_CYC(64)) dut (
        .clk_100MHz  (clk_100MHz),
        .rst_n       (rst_n),
        .c0_req      (c0_req),
        .c0_we       (c0_we),
        .c0_addr     (c0_addr),
        .c0_wdata    (c0_wdata),
        .c0_ack      (c0_ack),
        .c0_err      (c0_err),
        .c0_rdata    (c0_rdata),
        .c1_req      (c1_req),
        .c1_we       (c1_we),
        .c1_addr     (c1_addr),
        .c1_wdata    (c1_wdata),
        .c1_ack      (c1_ack),
        .c1_err      (c1_err),
        .c1_rdata    (c1_rdata),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_rd_data (mem_rd_data),
        .mem_rd_valid(mem_rd_valid),
        .mem_wr_ready(mem_wr_ready),
        .busy        (busy),
        .owner       (owner)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    int n_pass = 0;
    int n_total = 0;

    // Controller responder: completes a held request after cm_lat cycles, read valid held cm_hold cycles.
    logic [15:0] ctl_mem [logic [23:0]];
    bit  ctl_hang = 1'b0;
    bit  ctl_rand = 1'b0;
    int  ctl_lat  = 3;
    int  ctl_hold = 2;
    int  cm_lat, cm_hold;
    bit  cm_wr;
    logic [23:0] cm_a;
    logic [15:0] cm_d;

    function automatic logic [15:0] dflt(input logic [23:0] a);
        return a[15:0] ^ 16'hC3A5;
    endfunction

    initial begin
        mem_wr_ready = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = 16'h0;
        forever begin
            @(posedge clk_100MHz); #1;
            if (!ctl_hang && (mem_wr_req || mem_rd_req)) begin
                cm_lat  = ctl_rand ? int'($urandom_range(1, 4)) : ctl_lat;
                cm_hold = ctl_rand ? int'($urandom_range(1, 2)) : ctl_hold;
                cm_wr   = mem_wr_req;
                cm_a    = mem_addr;
                cm_d    = mem_wr_data;
                for (int k = 1; k < cm_lat; k++) begin
                    @(posedge clk_100MHz); #1;
                end
                if (cm_wr) begin
                    ctl_mem[cm_a] = cm_d;
                    mem_wr_ready  = 1'b1;
                    @(posedge clk_100MHz); #1;
                    mem_wr_ready  = 1'b0;
                end else begin
                    mem_rd_data  = ctl_mem.exists(cm_a) ? ctl_mem[cm_a] : dflt(cm_a);
                    mem_rd_valid = 1'b1;
                    for (int k = 0; k < cm_hold; k++) begin
                        @(posedge clk_100MHz); #1;
                    end
                    mem_rd_valid = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_100MHz); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        rst_n = 1'b1;
    endtask

    // Observation window statistics.
    int ack_n[2], ack_t[2];
    logic ack_err[2];
    int wr_hi, rd_hi, n_rise, both_req_n, both_ack_n, n_ack, first_ack_t;
    int rise_t[8];
    logic [23:0] rise_addr[8];
    logic [15:0] rise_wdata[8];
    logic rise_own[8];
    int ack_seq[8];
    logic busy_at_ack, busy_after_ack, prev_req;

    task automatic watch(input int n, input bit drop);
        ack_n = '{0, 0}; ack_t = '{-1, -1}; ack_err = '{1'b0, 1'b0};
        wr_hi = 0; rd_hi = 0; n_rise = 0; both_req_n = 0; both_ack_n = 0; n_ack = 0;
        first_ack_t = -10; busy_at_ack = 1'bx; busy_after_ack = 1'bx;
        prev_req = mem_wr_req || mem_rd_req;
        for (int t = 1; t <= n; t++) begin
            tick();
            if (mem_wr_req) wr_hi++;
            if (mem_rd_req) rd_hi++;
            if (mem_wr_req && mem_rd_req) both_req_n++;
            if (c0_ack && c1_ack) both_ack_n++;
            if ((mem_wr_req || mem_rd_req) && !prev_req && n_rise < 8) begin
                rise_t[n_rise] = t; rise_addr[n_rise] = mem_addr;
                rise_wdata[n_rise] = mem_wr_data; rise_own[n_rise] = owner;
                n_rise++;
            end
            prev_req = mem_wr_req || mem_rd_req;
            if (t == first_ack_t + 1) busy_after_ack = busy;
            for (int c = 0; c < 2; c++) begin
                if (acks[c]) begin
                    if (ack_n[c] == 0) begin
                        ack_t[c] = t;
                        ack_err[c] = (c == 0) ? c0_err : c1_err;
                    end
                    ack_n[c]++;
                    if (n_ack < 8) ack_seq[n_ack] = c;
                    if (n_ack == 0) begin first_ack_t = t; busy_at_ack = busy; end
                    n_ack++;
                end
            end
            if (drop && c0_ack) c0_req = 1'b0;
            if (drop && c1_ack) c1_req = 1'b0;
        end
    endtask

    // Random-phase client and reference state.
    bit          pend[2], snap[2], twe[2];
    logic [23:0] taddr[2];
    logic [15:0] twd[2];
    logic [15:0] ref_mem [logic [23:0]];
    bit          model_owner, in_txn, cur, gi, exp_g;
    int          cyc, free_at, n_done;

    task automatic drive_clients();
        c0_req = pend[0]; c0_we = twe[0]; c0_addr = taddr[0]; c0_wdata = twd[0];
        c1_req = pend[1]; c1_we = twe[1]; c1_addr = taddr[1]; c1_wdata = twd[1];
    endtask

    function automatic logic [15:0] ref_read(input logic [23:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    initial begin
        c0_req = 0; c0_we = 0; c0_addr = 0; c0_wdata = 0;
        c1_req = 0; c1_we = 0; c1_addr = 0; c1_wdata = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        // Reset state
        chk("rst_mem_rd_req", 32'(mem_rd_req), 0);
        chk("rst_mem_wr_req", 32'(mem_wr_req), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wr_data", 32'(mem_wr_data), 0);
        chk("rst_acks", 32'({c1_ack, c0_ack, c1_err, c0_err}), 0);
        chk("rst_rdata", {c1_rdata, c0_rdata}, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 1);
        do_reset();

        // Both clients request continuously from reset: c0 wins first, then strict alternation.
        c0_we = 1; c0_addr = 24'h000100; c0_wdata = 16'h1111; c0_req = 1;
        c1_we = 0; c1_addr = 24'h000200; c1_req = 1;
        watch(60, 1'b0);
        for (int k = 0; k < 4; k++) chk("rr_order", 32'(ack_seq[k]), 32'(k % 2));
        chk("rr_ack_overlap", 32'(both_ack_n), 0);
        chk("rr_req_overlap", 32'(both_req_n), 0);
        c0_req = 0; c1_req = 0;
        watch(10, 1'b0);

        // Single write on client 0, controller ready 3 cycles after the request.
        c0_we = 1; c0_addr = 24'h123456; c0_wdata = 16'hBEEF; c0_req = 1;
        watch(20, 1'b1);
        chk("wr_req_cycles", 32'(wr_hi), 3);
        chk("wr_addr", 32'(rise_addr[0]), 32'h123456);
        chk("wr_data", 32'(rise_wdata[0]), 32'hBEEF);
        chk("wr_c0_ack_count", 32'(ack_n[0]), 1);
        chk("wr_c0_err", 32'(ack_err[0]), 0);
        chk("wr_ack_latency", 32'(ack_t[0] - rise_t[0]), 3);
        chk("wr_busy_in_gap", 32'(busy_at_ack), 1);
        chk("wr_busy_idle", 32'(busy_after_ack), 0);
        chk("wr_c1_no_ack", 32'(ack_n[1]), 0);

        // Single read on client 1 with rd_valid held two cycles.
        ctl_mem[24'h000010] = 16'h5A5A;
        c1_we = 0; c1_addr = 24'h000010; c1_req = 1;
        watch(20, 1'b1);
        chk("rd_txn_count", 32'(n_rise), 1);
        chk("rd_req_cycles", 32'(rd_hi), 3);
        chk("rd_c1_ack_count", 32'(ack_n[1]), 1);
        chk("rd_c1_rdata", 32'(c1_rdata), 32'h5A5A);
        chk("rd_c1_err", 32'(ack_err[1]), 0);
        chk("rd_owner", 32'(rise_own[0]), 1);

        // Controller never answers: abort after 64 cycles, rdata unchanged.
        ctl_hang = 1'b1;
        c1_we = 0; c1_addr = 24'h000300; c1_req = 1;
        watch(100, 1'b1);
        chk("to_req_cycles", 32'(rd_hi), 64);
        chk("to_ack_count", 32'(ack_n[1]), 1);
        chk("to_err", 32'(ack_err[1]), 1);
        chk("to_ack_time", 32'(ack_t[1] - rise_t[0]), 64);
        chk("to_rdata_kept", 32'(c1_rdata), 32'h5A5A);

        // Reset pulsed while waiting for read data.
        c0_we = 0; c0_addr = 24'h002222; c0_req = 1;
        repeat (3) tick();
        chk("rr_wait_rd", 32'(mem_rd_req), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_rd_req", 32'(mem_rd_req), 0);
        chk("arst_busy", 32'(busy), 0);
        c0_req = 0;
        repeat (2) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        rst_n = 1'b1;
        watch(10, 1'b1);
        chk("arst_no_ack", 32'(ack_n[0] + ack_n[1]), 0);
        ctl_hang = 1'b0;
        c0_we = 1; c0_addr = 24'h003333; c0_wdata = 16'h1234; c0_req = 1;
        watch(20, 1'b1);
        chk("arst_next_ack", 32'(ack_n[0]), 1);
        chk("arst_next_err", 32'(ack_err[0]), 0);

        // Client 0 drops req right after its grant while client 1 waits.
        c0_we = 1; c0_addr = 24'h004444; c0_wdata = 16'h0F0F; c0_req = 1;
        tick();
        chk("drop_grant_c0", 32'({mem_wr_req, owner}), 32'h2);
        c0_req = 0;
        c1_we = 0; c1_addr = 24'h005555; c1_req = 1;
        watch(30, 1'b1);
        chk("drop_c0_ack", 32'(ack_n[0]), 1);
        chk("drop_c1_gap", 32'(rise_t[0] - ack_t[0]), 2);
        chk("drop_c1_addr", 32'(rise_addr[0]), 32'h005555);
        chk("drop_c1_owner", 32'(rise_own[0]), 1);
        chk("drop_c1_ack", 32'(ack_n[1]), 1);

        // Randomized traffic against the reference model.
        do_reset();
        ctl_rand = 1'b1;
        pend = '{0, 0}; twe = '{0, 0}; taddr = '{0, 0}; twd = '{0, 0};
        model_owner = 1'b1; in_txn = 1'b0; cur = 1'b0;
        cyc = 0; free_at = 0; n_done = 0;
        for (int it = 0; it < 3000 && n_done < 80; it++) begin
            for (int c = 0; c < 2; c++) begin
                if (!pend[c] && $urandom_range(0, 2) == 0) begin
                    pend[c]  = 1'b1;
                    twe[c]   = 1'($urandom_range(0, 1));
                    taddr[c] = 24'hA00000 + 24'($urandom_range(0, 5)) * 24'h001001;
                    twd[c]   = 16'($urandom);
                end
            end
            drive_clients();
            snap = pend;
            tick();
            cyc++;
            if (!in_txn) begin
                exp_g = (cyc >= free_at) && (snap[0] || snap[1]);
                chk("rnd_grant", 32'(mem_rd_req | mem_wr_req), 32'(exp_g));
                chk("rnd_spurious_ack", 32'(acks), 0);
                if (mem_rd_req | mem_wr_req) begin
                    gi = (snap[0] && snap[1]) ? !model_owner : snap[1];
                    chk("rnd_owner", 32'(owner), 32'(gi));
                    chk("rnd_addr", 32'(mem_addr), 32'(taddr[gi]));
                    chk("rnd_kind", 32'({mem_wr_req, mem_rd_req}), twe[gi] ? 32'h2 : 32'h1);
                    if (twe[gi]) chk("rnd_wdata", 32'(mem_wr_data), 32'(twd[gi]));
                    model_owner = gi; cur = gi; in_txn = 1'b1;
                end
            end else if (acks != 2'b00) begin
                chk("rnd_ack_who", 32'(acks), cur ? 32'h2 : 32'h1);
                chk("rnd_err", 32'({c1_err, c0_err}), 0);
                chk("rnd_req_drop", 32'(mem_rd_req | mem_wr_req), 0);
                if (!twe[cur]) chk("rnd_rdata", 32'(cur ? c1_rdata : c0_rdata), 32'(ref_read(taddr[cur])));
                else ref_mem[taddr[cur]] = twd[cur];
                pend[cur] = 1'b0;
                drive_clients();
                in_txn = 1'b0; free_at = cyc + 2; n_done++;
            end else begin
                chk("rnd_req_held", 32'({mem_wr_req, mem_rd_req}), twe[cur] ? 32'h2 : 32'h1);
            end
        end
        chk("rnd_completed", 32'(n_done >= 80), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
